// File: rtl/t05_huff_pkg.sv
// Shared Huffman-tree definitions used by the decoder and the codebook synthesis block.
//   dec_state_e  : decoder FSM states
//   child_kind_e : classification of a 9-bit child field
//   NULL_CHILD   : encoding of an absent child
//   LEFT_*/RIGHT_* : child field positions inside the 71-bit htree word
//   child_kind() : decode a child field into its kind
package t05_huff_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_BIT,
        ST_EMIT,
        ST_DONE,
        ST_ERROR
    } dec_state_e;

    typedef enum logic [1:0] {
        CHILD_LEAF,
        CHILD_SUM,
        CHILD_NULL
    } child_kind_e;

    localparam logic [8:0] NULL_CHILD = 9'h180;

    localparam int unsigned LEFT_HI  = 63;
    localparam int unsigned LEFT_LO  = 55;
    localparam int unsigned RIGHT_HI = 54;
    localparam int unsigned RIGHT_LO = 46;

    // NULL_CHILD has bit 8 set, so it must be tested before the sum-node check.
    function automatic child_kind_e child_kind(input logic [8:0] child);
        child_kind_e kind;
        if (child == NULL_CHILD) begin
            kind = CHILD_NULL;
        end else if (child[8]) begin
            kind = CHILD_SUM;
        end else begin
            kind = CHILD_LEAF;
        end
        return kind;
    endfunction

endpackage

// File: rtl/t05_huff_node_reg.sv
// Left/right child pair register for one Huffman tree node.
//   clk, rst              : clock, asynchronous active-low reset
//   load_mem, mem_*       : load the pair from an htree memory word (highest priority)
//   load_root, root_*     : load the pair from the cached root node
//   left, right           : stored children
module t05_huff_node_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_mem,
    input  logic [8:0] mem_left,
    input  logic [8:0] mem_right,
    input  logic       load_root,
    input  logic [8:0] root_left,
    input  logic [8:0] root_right,
    output logic [8:0] left,
    output logic [8:0] right
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            left  <= '0;
            right <= '0;
        end else if (load_mem) begin
            left  <= mem_left;
            right <= mem_right;
        end else if (load_root) begin
            left  <= root_left;
            right <= root_right;
        end
    end

endmodule

// File: rtl/t05_huff_decoder.sv
// Huffman decoder: walks the htree from the root one code bit at a time and
// emits an 8-bit character at every leaf, until char_total characters are out.
//   clk, rst                      : clock, asynchronous active-low reset
//   start, max_index, char_total  : launch a decode (root index, character count)
//   htree_req/index/ack, h_element: htree memory read port
//   bit_in/valid/ready            : compressed bit stream input
//   char_out/valid/ready          : decoded character output
//   finished, err                 : completion / null-child error status
module t05_huff_decoder
    import t05_huff_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [6:0]       max_index,
    input  logic [CNT_W-1:0] char_total,
    output logic             htree_req,
    output logic [6:0]       htree_index,
    input  logic             htree_ack,
    input  logic [70:0]      h_element,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [7:0]       char_out,
    output logic             char_valid,
    input  logic             char_ready,
    output logic             finished,
    output logic             err
);

    dec_state_e       state_q, state_d;
    logic [6:0]       root_q, idx_q;
    logic [CNT_W-1:0] total_q, count_q, count_inc;
    logic [7:0]       char_q;
    logic             root_valid_q;

    logic [8:0]  mem_left, mem_right;
    logic [8:0]  cur_left, cur_right;
    logic [8:0]  root_left, root_right;
    logic [8:0]  sel_child;
    child_kind_e sel_kind;
    logic        accept_start, fetch_done, root_load, bit_take, char_take, reload_root;
    logic        unused_elem_bits;

    assign mem_left   = h_element[LEFT_HI:LEFT_LO];
    assign mem_right  = h_element[RIGHT_HI:RIGHT_LO];
    assign unused_elem_bits = ^{h_element[70:64], h_element[45:0]};

    assign accept_start = start && (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
    assign fetch_done   = (state_q == ST_FETCH) && htree_ack;
    assign root_load    = fetch_done && (idx_q == root_q);
    assign bit_take     = (state_q == ST_WAIT_BIT) && bit_valid;
    assign char_take    = (state_q == ST_EMIT) && char_ready;
    assign reload_root  = char_take && root_valid_q;
    assign sel_child    = bit_in ? cur_right : cur_left;
    assign sel_kind     = child_kind(sel_child);
    assign count_inc    = count_q + 1'b1;

    t05_huff_node_reg u_cur_node (
        .clk        (clk),
        .rst        (rst),
        .load_mem   (fetch_done),
        .mem_left   (mem_left),
        .mem_right  (mem_right),
        .load_root  (reload_root),
        .root_left  (root_left),
        .root_right (root_right),
        .left       (cur_left),
        .right      (cur_right)
    );

    t05_huff_node_reg u_root_cache (
        .clk        (clk),
        .rst        (rst),
        .load_mem   (root_load),
        .mem_left   (mem_left),
        .mem_right  (mem_right),
        .load_root  (1'b0),
        .root_left  ('0),
        .root_right ('0),
        .left       (root_left),
        .right      (root_right)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d = (char_total == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (htree_ack) begin
                    state_d = ST_WAIT_BIT;
                end
            end
            ST_WAIT_BIT: begin
                if (bit_valid) begin
                    unique case (sel_kind)
                        CHILD_NULL: state_d = ST_ERROR;
                        CHILD_SUM:  state_d = ST_FETCH;
                        default:    state_d = ST_EMIT;
                    endcase
                end
            end
            ST_EMIT: begin
                if (char_ready) begin
                    if (count_inc == total_q) begin
                        state_d = ST_DONE;
                    end else begin
                        // The root is always the first node fetched, so the
                        // cache is valid here; the refetch path is a safeguard.
                        state_d = root_valid_q ? ST_WAIT_BIT : ST_FETCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            root_q       <= '0;
            idx_q        <= '0;
            total_q      <= '0;
            count_q      <= '0;
            char_q       <= '0;
            root_valid_q <= 1'b0;
        end else begin
            if (accept_start) begin
                root_q       <= max_index;
                idx_q        <= max_index;
                total_q      <= char_total;
                count_q      <= '0;
                root_valid_q <= 1'b0;
            end
            if (root_load) begin
                root_valid_q <= 1'b1;
            end
            if (bit_take && (sel_kind == CHILD_SUM)) begin
                idx_q <= sel_child[6:0];
            end
            if (bit_take && (sel_kind == CHILD_LEAF)) begin
                char_q <= sel_child[7:0];
            end
            if (char_take) begin
                count_q <= count_inc;
                if (!root_valid_q) begin
                    idx_q <= root_q;
                end
            end
        end
    end

    always_comb begin
        htree_req  = (state_q == ST_FETCH);
        bit_ready  = (state_q == ST_WAIT_BIT);
        char_valid = (state_q == ST_EMIT);
        finished   = (state_q == ST_DONE);
        err        = (state_q == ST_ERROR);
    end

    assign htree_index = idx_q;
    assign char_out    = char_q;

endmodule
